// File: rtl/spi_master_arbiter.sv
// Two-requester burst arbiter driving an SPI master core through its
// 16-bit register port with two-cycle strobes.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   req[1:0]            per-requester burst request
//   tx_data0/1          byte to send for each requester
//   last[1:0]           current byte ends the burst
//   ack, rx_valid       one-cycle pulse to owner: byte done, rx_data valid
//   rx_data             received byte
//   err                 one-cycle pulse: burst aborted on timeout
//   busy                sequencer not idle
//   spi_select, mem_addr, data_from_cpu, write_n, read_n, data_to_cpu
//                       core register port
//   readyfordata        core TRDY
//   dataavailable       core RRDY
module spi_master_arbiter #(
    parameter logic [15:0] SS_MASK0 = 16'h0001,
    parameter logic [15:0] SS_MASK1 = 16'h0001,
    parameter int          TIMEOUT  = 8192
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [7:0]  tx_data0,
    input  logic [7:0]  tx_data1,
    input  logic [1:0]  last,
    output logic [1:0]  ack,
    output logic [7:0]  rx_data,
    output logic [1:0]  rx_valid,
    output logic [1:0]  err,
    output logic        busy,
    output logic        spi_select,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    output logic        write_n,
    output logic        read_n,
    input  logic [15:0] data_to_cpu,
    input  logic        readyfordata,
    input  logic        dataavailable
);

    typedef enum logic [3:0] {
        IDLE,
        SEL,
        SSO_ON,
        WAIT_TRDY,
        DWR,
        WAIT_RRDY,
        DRD,
        ACK,
        SSO_OFF
    } state_t;

    localparam logic [13:0] TO_LAST = 14'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  ph;
    logic [13:0] wcnt;
    logic        g;
    logic        rr_ptr;
    logic        last_q;
    logic [7:0]  byte_q;

    logic        acc_st;
    logic        acc_act;
    logic        acc_done;
    logic        wait_st;
    logic        to_hit;
    logic        to_fire;
    logic        g_pick;
    logic [1:0]  gnt_oh;

    // Upper half of the read word carries status bits we never use.
    logic        unused_hi;
    assign unused_hi = ^data_to_cpu[15:8];

    // Every access state runs three phases: two strobe cycles and one
    // idle cycle so the core's edge detector re-arms before the next one.
    always_comb begin
        acc_st   = (state == SEL) || (state == SSO_ON) || (state == DWR) ||
                   (state == DRD) || (state == SSO_OFF);
        acc_act  = acc_st && (ph != 2'd2);
        acc_done = acc_st && (ph == 2'd2);
        wait_st  = (state == WAIT_TRDY) || (state == WAIT_RRDY);
        to_hit   = wait_st && (wcnt == TO_LAST);
        g_pick   = req[rr_ptr] ? rr_ptr : ~rr_ptr;
        gnt_oh   = g ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_nx = state;
        to_fire  = 1'b0;
        unique case (state)
            IDLE:      if (|req) state_nx = SEL;
            SEL:       if (acc_done) state_nx = SSO_ON;
            SSO_ON:    if (acc_done) state_nx = WAIT_TRDY;
            WAIT_TRDY: begin
                if (readyfordata) begin
                    state_nx = DWR;
                end else if (to_hit) begin
                    state_nx = SSO_OFF;
                    to_fire  = 1'b1;
                end
            end
            DWR:       if (acc_done) state_nx = WAIT_RRDY;
            WAIT_RRDY: begin
                if (dataavailable) begin
                    state_nx = DRD;
                end else if (to_hit) begin
                    state_nx = SSO_OFF;
                    to_fire  = 1'b1;
                end
            end
            DRD:       if (acc_done) state_nx = ACK;
            // A dropped request ends the burst after the byte in flight.
            ACK:       state_nx = (last_q || !req[g]) ? SSO_OFF : WAIT_TRDY;
            SSO_OFF:   if (acc_done) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        spi_select    = acc_act;
        write_n       = !(acc_act && (state != DRD));
        read_n        = !(acc_act && (state == DRD));
        mem_addr      = 3'd0;
        data_from_cpu = 16'h0000;
        if (acc_act) begin
            unique case (state)
                SEL: begin
                    mem_addr      = 3'd5;
                    data_from_cpu = g ? SS_MASK1 : SS_MASK0;
                end
                SSO_ON: begin
                    mem_addr      = 3'd3;
                    data_from_cpu = 16'h0400;
                end
                DWR: begin
                    mem_addr      = 3'd1;
                    data_from_cpu = {8'h00, byte_q};
                end
                SSO_OFF: begin
                    mem_addr      = 3'd3;
                    data_from_cpu = 16'h0000;
                end
                default: begin
                    mem_addr      = 3'd0;
                    data_from_cpu = 16'h0000;
                end
            endcase
        end
        ack      = (state == ACK) ? gnt_oh : 2'b00;
        rx_valid = ack;
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ph      <= 2'd0;
            wcnt    <= 14'd0;
            g       <= 1'b0;
            rr_ptr  <= 1'b0;
            last_q  <= 1'b0;
            byte_q  <= 8'h00;
            rx_data <= 8'h00;
            err     <= 2'b00;
        end else begin
            state <= state_nx;
            ph    <= (acc_st && !acc_done) ? ph + 2'd1 : 2'd0;
            // Wait states are never adjacent, so leaving one clears it.
            wcnt  <= wait_st ? wcnt + 14'd1 : 14'd0;
            err   <= to_fire ? gnt_oh : 2'b00;
            if (state == IDLE && |req) begin
                g <= g_pick;
            end
            // Byte and its last flag are captured as the data write starts.
            if (state == WAIT_TRDY && readyfordata) begin
                byte_q <= g ? tx_data1 : tx_data0;
                last_q <= last[g];
            end
            if (state == DRD && ph == 2'd1) begin
                rx_data <= data_to_cpu[7:0];
            end
            if (state == SSO_OFF && acc_done) begin
                rr_ptr <= ~g;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a loopback SPI core model,
// bus protocol monitor and per-requester burst drivers.
module tb_spi_master_arbiter;

    localparam int          TO = 40;
    localparam logic [15:0] M0 = 16'h0001;
    localparam logic [15:0] M1 = 16'h0002;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [7:0]  tx_data0;
    logic [7:0]  tx_data1;
    logic [1:0]  last;
    logic [1:0]  ack;
    logic [7:0]  rx_data;
    logic [1:0]  rx_valid;
    logic [1:0]  err;
    logic        busy;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic        write_n;
    logic        read_n;
    logic [15:0] data_to_cpu;
    logic        readyfordata;
    logic        dataavailable;

    spi_master_arbiter #(
        .SS_MASK0 (M0),
        .SS_MASK1 (M1),
        .TIMEOUT  (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .tx_data0      (tx_data0),
        .tx_data1      (tx_data1),
        .last          (last),
        .ack           (ack),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .err           (err),
        .busy          (busy),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .data_from_cpu (data_from_cpu),
        .write_n       (write_n),
        .read_n        (read_n),
        .data_to_cpu   (data_to_cpu),
        .readyfordata  (readyfordata),
        .dataavailable (dataavailable)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core model: loops the written byte back after a fixed shift time.
    logic [7:0] rxreg;
    logic [7:0] sh_byte;
    int         sh_cnt;
    logic       wn_d;
    logic       rn_d;
    logic       no_rrdy;

    assign data_to_cpu = {8'hEE, rxreg};

    initial begin
        readyfordata  = 1'b1;
        dataavailable = 1'b0;
        rxreg         = 8'h00;
        sh_byte       = 8'h00;
        sh_cnt        = 0;
        wn_d          = 1'b1;
        rn_d          = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                readyfordata  = 1'b1;
                dataavailable = 1'b0;
                rxreg         = 8'h00;
                sh_cnt        = 0;
                wn_d          = 1'b1;
                rn_d          = 1'b1;
            end else begin
                if (sh_cnt > 0) begin
                    sh_cnt--;
                    if (sh_cnt == 0) begin
                        readyfordata = 1'b1;
                        if (!no_rrdy) begin
                            dataavailable = 1'b1;
                            rxreg         = sh_byte;
                        end
                    end
                end
                if (!write_n && wn_d && mem_addr == 3'd1) begin
                    readyfordata = 1'b0;
                    sh_byte      = data_from_cpu[7:0];
                    sh_cnt       = 6;
                end
                if (!read_n && rn_d && mem_addr == 3'd0) begin
                    dataavailable = 1'b0;
                end
                wn_d = write_n;
                rn_d = read_n;
            end
        end
    end

    // Bus monitor and event logs.
    logic [19:0] acc_log[$];
    logic [19:0] exp_acc[$];
    logic [11:0] ack_log[$];
    logic [11:0] exp_ack[$];
    logic [1:0]  err_log[$];
    int          cyc = 0;
    int          w1_cyc = 0;
    int          err_cyc = 0;

    initial begin
        logic        in_acc;
        logic        trdy_prev;
        int          len;
        int          gap;
        logic [19:0] first;
        logic [19:0] cur;
        in_acc    = 1'b0;
        trdy_prev = 1'b0;
        len       = 0;
        gap       = 1;
        first     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                in_acc = 1'b0;
                gap    = 1;
            end else begin
                cur = {!write_n, mem_addr, data_from_cpu};
                if (!write_n || !read_n) begin
                    chk("strobe_excl", 32'(write_n | read_n), 1);
                    chk("strobe_sel", 32'(spi_select), 1);
                    if (!in_acc) begin
                        chk("idle_gap", 32'(gap >= 1), 1);
                        acc_log.push_back(cur);
                        first  = cur;
                        len    = 1;
                        in_acc = 1'b1;
                        if (!write_n && mem_addr == 3'd1) begin
                            chk("w1_trdy", 32'(trdy_prev), 1);
                            w1_cyc = cyc;
                        end
                    end else begin
                        len++;
                        chk("acc_hold", 32'(cur), 32'(first));
                    end
                    gap = 0;
                end else begin
                    if (in_acc) begin
                        chk("strobe_len", 32'(len), 2);
                        in_acc = 1'b0;
                    end
                    gap++;
                    chk("bus_idle", 32'({spi_select, mem_addr, data_from_cpu}), 0);
                end
                if (ack != 2'b00) begin
                    chk("ack_rxv", 32'(rx_valid), 32'(ack));
                    ack_log.push_back({ack, rx_valid, rx_data});
                end
                if (err != 2'b00) begin
                    err_log.push_back(err);
                    err_cyc = cyc;
                end
            end
            trdy_prev = readyfordata;
        end
    end

    // Requester drivers: each queue entry is {last, byte}.
    logic [8:0] rq[2][$];

    task automatic present(input int i);
        if (i == 0) begin
            tx_data0 = rq[0][0][7:0];
            last[0]  = rq[0][0][8];
        end else begin
            tx_data1 = rq[1][0][7:0];
            last[1]  = rq[1][0][8];
        end
    endtask

    task automatic drive(input int i);
        logic [8:0] popped;
        if (!reset_n) return;
        if (req[i]) begin
            if (err[i]) begin
                req[i] = 1'b0;
                rq[i].delete();
            end else if (ack[i]) begin
                popped = rq[i].pop_front();
                if (popped[8] || rq[i].size() == 0) req[i] = 1'b0;
                else present(i);
            end
        end else if (rq[i].size() > 0) begin
            present(i);
            req[i] = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            drive(0);
            drive(1);
        end
    end

    task automatic exp_open(input logic [15:0] mask);
        exp_acc.push_back({1'b1, 3'd5, mask});
        exp_acc.push_back({1'b1, 3'd3, 16'h0400});
    endtask

    task automatic exp_byte(input logic [1:0] oh, input logic [7:0] b);
        exp_acc.push_back({1'b1, 3'd1, 8'h00, b});
        exp_acc.push_back({1'b0, 3'd0, 16'h0000});
        exp_ack.push_back({oh, oh, b});
    endtask

    task automatic exp_close();
        exp_acc.push_back({1'b1, 3'd3, 16'h0000});
    endtask

    task automatic cmp_logs(input string tag, input int n_err_exp);
        chk({tag, "_nacc"}, 32'(acc_log.size()), 32'(exp_acc.size()));
        foreach (exp_acc[k]) begin
            if (k < acc_log.size())
                chk($sformatf("%s_acc%0d", tag, k), 32'(acc_log[k]), 32'(exp_acc[k]));
        end
        chk({tag, "_nack"}, 32'(ack_log.size()), 32'(exp_ack.size()));
        foreach (exp_ack[k]) begin
            if (k < ack_log.size())
                chk($sformatf("%s_ack%0d", tag, k), 32'(ack_log[k]), 32'(exp_ack[k]));
        end
        chk({tag, "_nerr"}, 32'(err_log.size()), 32'(n_err_exp));
        acc_log.delete();
        exp_acc.delete();
        ack_log.delete();
        exp_ack.delete();
        err_log.delete();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || req != 2'b00 || rq[0].size() != 0 ||
                    rq[1].size() != 0) && n < 3000);
        chk({tag, "_done"}, 32'(n < 3000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_rxv"}, 32'(rx_valid), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rxd"}, 32'(rx_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_bus"}, 32'({spi_select, write_n, read_n, mem_addr, data_from_cpu}),
            32'({1'b0, 1'b1, 1'b1, 3'd0, 16'h0000}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n  = 1'b0;
        req      = 2'b00;
        tx_data0 = 8'h00;
        tx_data1 = 8'h00;
        last     = 2'b00;
        no_rrdy  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;

        // Single byte, requester 0
        rq[0].push_back({1'b1, 8'hA5});
        exp_open(M0);
        exp_byte(2'b01, 8'hA5);
        exp_close();
        wait_done("single");
        cmp_logs("single", 0);
        chk("single_busy", 32'(busy), 0);

        // Three-byte burst, requester 1, SSO held across all bytes
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        exp_open(M1);
        exp_byte(2'b10, 8'h11);
        exp_byte(2'b10, 8'h22);
        exp_byte(2'b10, 8'h33);
        exp_close();
        wait_done("burst3");
        cmp_logs("burst3", 0);

        // Request withdrawn after a non-last byte
        rq[1].push_back({1'b0, 8'h12});
        exp_open(M1);
        exp_byte(2'b10, 8'h12);
        exp_close();
        wait_done("withdraw");
        cmp_logs("withdraw", 0);

        // Contention from reset: grants alternate 0,1,0,1
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        rq[0].push_back({1'b1, 8'h5A});
        rq[0].push_back({1'b1, 8'hC3});
        rq[1].push_back({1'b1, 8'h3C});
        rq[1].push_back({1'b1, 8'h96});
        reset_n = 1'b1;
        exp_open(M0); exp_byte(2'b01, 8'h5A); exp_close();
        exp_open(M1); exp_byte(2'b10, 8'h3C); exp_close();
        exp_open(M0); exp_byte(2'b01, 8'hC3); exp_close();
        exp_open(M1); exp_byte(2'b10, 8'h96); exp_close();
        wait_done("contend");
        cmp_logs("contend", 0);

        // Timeout while waiting for RRDY
        no_rrdy = 1'b1;
        rq[0].push_back({1'b1, 8'h77});
        exp_open(M0);
        exp_acc.push_back({1'b1, 3'd1, 16'h0077});
        exp_close();
        wait_done("tmo");
        chk("tmo_errval", 32'(err_log.size() > 0 ? err_log[0] : 2'b00), 32'(2'b01));
        // WAIT_RRDY is entered 3 cycles after the first addr1 strobe cycle.
        chk("tmo_time", 32'(err_cyc - w1_cyc), 32'(TO + 3));
        cmp_logs("tmo", 1);
        no_rrdy = 1'b0;

        // Reset during WAIT_RRDY of the second byte
        rq[0].push_back({1'b0, 8'h44});
        rq[0].push_back({1'b0, 8'h55});
        rq[0].push_back({1'b1, 8'h66});
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (acc_log.size() < 5 && n < 500);
        chk("mid_reach", 32'(n < 500), 1);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        req = 2'b00;
        rq[0].delete();
        rq[1].delete();
        exp_open(M0);
        exp_byte(2'b01, 8'h44);
        exp_acc.push_back({1'b1, 3'd1, 16'h0055});
        cmp_logs("mid", 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Normal burst after reset release
        rq[0].push_back({1'b1, 8'h99});
        exp_open(M0);
        exp_byte(2'b01, 8'h99);
        exp_close();
        wait_done("after");
        cmp_logs("after", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Sequences the SPI master core through its 16-bit register port (mem_addr 0..6, two-cycle read/write strobes) so that two hardware requesters can share the core without CPU involvement.
- Performs round-robin arbitration and holds the grant for the whole burst, until the byte marked "last" completes.
- For each burst it programs slave-enable, forces SS_n via control SSO, and then moves bytes one at a time using the core's readyfordata and dataavailable.
- Sits between the client logic and the SPI master core's Avalon slave port.

Parameters:
- SS_MASK0, 16'h0001, value written to slave-enable (addr 5) for requester 0.
- SS_MASK1, 16'h0001, value written to slave-enable (addr 5) for requester 1.
- TIMEOUT, 8192, maximum number of clk cycles spent waiting in WAIT_TRDY or WAIT_RRDY before the burst is aborted.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  2  per-requester burst request; held high until ack of the last byte
- tx_data0  in  8  requester 0 byte to send; stable while req[0] is high and not yet acked
- tx_data1  in  8  requester 1 byte to send
- last  in  2  per-requester flag: the current byte ends the burst
- ack  out  2  one-cycle pulse: current byte's receive data is delivered, present the next byte
- rx_data  out  8  received byte, valid when rx_valid is high
- rx_valid  out  2  one-cycle pulse to the owning requester, coincident with ack
- err  out  2  one-cycle pulse: burst aborted on timeout
- busy  out  1  high whenever state is not IDLE
- spi_select  out  1  core chip select
- mem_addr  out  3  core register address
- data_from_cpu  out  16  core write data
- write_n  out  1  core write, active low
- read_n  out  1  core read, active low
- data_to_cpu  in  16  core read data
- readyfordata  in  1  core TRDY
- dataavailable  in  1  core RRDY

Behaviour:
- Reset values: state IDLE; ack = rx_valid = err = 0; rx_data = 0; busy = 0; spi_select = 0; write_n = read_n = 1; mem_addr = 0; data_from_cpu = 0; rr_ptr = 0 (requester 0 has priority first).
- Bus access: every core access asserts spi_select plus write_n or read_n for exactly 2 cycles, with mem_addr and data_from_cpu held constant. All bus signals return to idle values for at least 1 cycle between accesses, so the core's rising-edge strobe detector re-arms.
- Read data: data_to_cpu is sampled at the clk edge that ends the 2nd read cycle.
- IDLE: if any req bit is set, grant g = the requester at rr_ptr if it is requesting, otherwise the other one. Latch g and go to SEL.
- SEL: write addr 5 with SS_MASKg, then go to SSO_ON.
- SSO_ON: write addr 3 with 16'h0400 (SSO = 1, all interrupt enables 0), then go to WAIT_TRDY.
- WAIT_TRDY: wait for readyfordata = 1, then go to DWR.
- DWR: write addr 1 with {8'h00, tx_data_g}, then go to WAIT_RRDY.
- WAIT_RRDY: wait for dataavailable = 1, then go to DRD.
- DRD: read addr 0; rx_data <= data_to_cpu[7:0].
- After DRD, in the next cycle, pulse ack[g] and rx_valid[g]:
  - if last[g] was 1 (sampled when DWR was issued), go to SSO_OFF;
  - otherwise go to WAIT_TRDY for the next byte.
- SSO_OFF: write addr 3 with 16'h0000; set rr_ptr = ~g; go to IDLE.
- Timeout: a 14-bit counter clears on entry to WAIT_TRDY and WAIT_RRDY and increments on every cycle spent there. When it reaches TIMEOUT-1, pulse err[g] and go to SSO_OFF without acking.
- Request withdrawn mid-burst: if req[g] drops, the byte in flight completes and is acked, then the block goes to SSO_OFF. No further bytes are sent.
- The other requester is never acked while a burst is in progress. Its req only influences arbitration in IDLE.
- Only one byte is outstanding at a time, so the core's TOE and ROE are never set by this block.
- Asynchronous reset mid-burst returns everything to the reset values. The SPI core is reset by the same reset_n, so no SSO clean-up write is needed.

Test Plan:
- Single byte: req = 2'b01, tx_data0 = 8'hA5, last = 01, core model loops MOSI back to MISO. Required: bus writes addr5 = 0001, addr3 = 0400, addr1 = 00A5, read addr0, addr3 = 0000; ack[0] and rx_valid[0] pulse once with rx_data = A5; busy falls afterwards.
- 3-byte burst: bytes 11, 22, 33, last asserted only on the 3rd byte. Required: exactly one addr5 write and one SSO_ON write; SS_n stays low across all 3 bytes; 3 ack pulses with rx_data 11, 22, 33.
- Contention: req = 2'b11 from reset, each requester sending single-byte bursts. Required: grant order 0, 1, 0, 1; the addr5 write uses SS_MASK0 and then SS_MASK1 in turn; ack[1] never pulses during requester 0's burst.
- Timeout: hold dataavailable = 0 in the core model. Required: err[g] pulses exactly TIMEOUT cycles after entering WAIT_RRDY, an addr3 = 0000 write follows, no ack is issued, state returns to IDLE.
- Protocol check: a monitor asserts that every access holds write_n or read_n low for exactly 2 cycles with 1 idle cycle between accesses, and that addr1 is written only while readyfordata = 1.
- Reset mid-burst: deassert reset_n during WAIT_RRDY of byte 2. Required: all outputs take reset values immediately; after release, a new req = 01 burst completes normally.
